// File: rtl/id_ex_fifo_if.sv
// ID/EX queue bus: the master side (ID push, EX pop, flush) drives requests,
// the queue (slave) returns the show-ahead head and status flags.
interface id_ex_fifo_if #(
  parameter int WIDTH = 180,
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH) + 1
);
  logic             flush;
  logic [WIDTH-1:0] wData;
  logic             wen;
  logic             pop;
  logic [WIDTH-1:0] rData;
  logic             isFull;
  logic             isEmpty;
  logic [CNTW-1:0]  count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wData, wen, pop,
    input  rData, isFull, isEmpty, count, overflow, underflow
  );

  modport slave (
    input  flush, wData, wen, pop,
    output rData, isFull, isEmpty, count, overflow, underflow
  );
endinterface

// File: rtl/id_ex_fifo.sv
// Circular ID/EX decoupling queue with show-ahead head; empty reads return an
// all-zero bubble so EX sees a NOP with every write-enable deasserted.
module id_ex_fifo #(
  parameter int WIDTH = 180,
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input logic        clk,
  input logic        rst_n,
  id_ex_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_count;

  // The extra MSB on each pointer is a wrap bit: equal index with differing
  // wrap bits means the writer has lapped the reader exactly once.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
  assign w_push  = bus.wen && !w_full && !bus.flush;
  assign w_pop   = bus.pop && !w_empty && !bus.flush;
  assign w_count = r_wptr - r_rptr;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= bus.wData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (bus.wen && w_full) begin
        r_overflow <= 1'b1;
      end
      if (bus.pop && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign bus.rData     = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign bus.isFull    = w_full;
  assign bus.isEmpty   = w_empty;
  assign bus.count     = CNTW'(w_count);
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;
endmodule

// File: tb/tb_id_ex_fifo.sv
// Randomized and directed bench for id_ex_fifo: a queue-based reference model
// predicts each post-edge state, and a negedge monitor compares it to the DUT.
module tb_id_ex_fifo;
  localparam int W    = 180;
  localparam int D    = 4;
  localparam int CW   = $clog2(D) + 1;

  typedef struct {
    logic [W-1:0]  rData;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          udf;
  } exp_t;

  logic clk;
  logic rst_n;

  id_ex_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

  id_ex_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [W-1:0] modelQ[$];
  bit           mOvf;
  bit           mUdf;
  exp_t         expQ[$];
  int           nChecks;
  int           nPass;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nChecks++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkState(input string tag, input exp_t e);
    checkOutput({tag, ".rData"},     bus.rData,          e.rData);
    checkOutput({tag, ".count"},     W'(bus.count),      W'(e.count));
    checkOutput({tag, ".isFull"},    W'(bus.isFull),     W'(e.full));
    checkOutput({tag, ".isEmpty"},   W'(bus.isEmpty),    W'(e.empty));
    checkOutput({tag, ".overflow"},  W'(bus.overflow),   W'(e.ovf));
    checkOutput({tag, ".underflow"}, W'(bus.underflow),  W'(e.udf));
  endtask

  function automatic exp_t resetState();
    exp_t e;
    e.rData = '0;
    e.count = '0;
    e.full  = 1'b0;
    e.empty = 1'b1;
    e.ovf   = 1'b0;
    e.udf   = 1'b0;
    return e;
  endfunction

  // Reference behaviour: a bounded queue with sticky error flags.
  task automatic modelStep(input bit w, input bit p, input bit f, input logic [W-1:0] d);
    exp_t e;
    bit   wasFull;
    bit   wasEmpty;
    wasFull  = (modelQ.size() == D);
    wasEmpty = (modelQ.size() == 0);
    if (f) begin
      modelQ.delete();
    end else begin
      if (w && wasFull)  mOvf = 1'b1;
      if (p && wasEmpty) mUdf = 1'b1;
      if (p && !wasEmpty) void'(modelQ.pop_front());
      if (w && !wasFull) modelQ.push_back(d);
    end
    e.rData = (modelQ.size() > 0) ? modelQ[0] : '0;
    e.count = CW'(modelQ.size());
    e.full  = (modelQ.size() == D);
    e.empty = (modelQ.size() == 0);
    e.ovf   = mOvf;
    e.udf   = mUdf;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input bit w, input bit p, input bit f, input logic [W-1:0] d);
    bus.wen   = w;
    bus.pop   = p;
    bus.flush = f;
    bus.wData = d;
    @(posedge clk);
    modelStep(w, p, f, d);
    #1;
    bus.wen   = 1'b0;
    bus.pop   = 1'b0;
    bus.flush = 1'b0;
  endtask

  function automatic logic [W-1:0] randData();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[W-1:0];
  endfunction

  // Asynchronous reset between edges; outputs must drop before the next edge.
  task automatic pulseReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkState("asyncReset", resetState());
    modelQ.delete();
    mOvf = 1'b0;
    mUdf = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkState("cycle", e);
      end
    end
  end

  initial begin
    nChecks   = 0;
    nPass     = 0;
    mOvf      = 1'b0;
    mUdf      = 1'b0;
    rst_n     = 1'b0;
    bus.wen   = 1'b0;
    bus.pop   = 1'b0;
    bus.flush = 1'b0;
    bus.wData = '0;
    #2;
    checkState("reset", resetState());
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus(0, 0, 0, '0);
    applyStimulus(0, 0, 0, '0);

    // Fill, then a dropped 5th push, then push+pop while full.
    applyStimulus(1, 0, 0, W'('hA));
    applyStimulus(1, 0, 0, W'('hB));
    applyStimulus(1, 0, 0, W'('hC));
    applyStimulus(1, 0, 0, W'('hD));
    applyStimulus(1, 0, 0, W'('h99));
    applyStimulus(1, 1, 0, W'('hE));

    // Drain to one entry, then stream through several pointer wraps.
    applyStimulus(0, 1, 0, '0);
    applyStimulus(0, 1, 0, '0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 1, 0, W'(32'h100 + i));
    end

    // Flush with simultaneous push and pop while three entries are held.
    applyStimulus(1, 0, 0, W'('h21));
    applyStimulus(1, 0, 0, W'('h22));
    applyStimulus(1, 1, 1, W'('hF));
    applyStimulus(0, 0, 0, '0);

    // Underflow, then push+pop on an empty queue.
    applyStimulus(0, 1, 0, '0);
    applyStimulus(1, 1, 0, W'('h5));
    applyStimulus(1, 0, 0, W'('h6));
    applyStimulus(1, 0, 0, W'('h7));
    pulseReset();
    applyStimulus(1, 0, 0, W'('h8));

    for (int i = 0; i < 400; i++) begin
      int wBias;
      wBias = (i < 200) ? 70 : 35;
      applyStimulus($urandom_range(0, 99) < wBias,
                    $urandom_range(0, 99) < 50,
                    $urandom_range(0, 99) < 3,
                    randData());
    end

    repeat (3) @(negedge clk);
    #1;
    checkOutput("scoreboardDrained", W'(expQ.size()), W'(0));
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
